// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch queue between a synchronous imem and decode.
//
// The fetch pc is registered and driven straight onto o_address_imem. The imem
// answers on i_q_imem within the same cycle; at the rising edge the pair
// {fetch_pc, q_imem} is pushed at the tail and fetch_pc advances. Decode pops
// the head with i_instr_ready while o_instr_valid is high. A redirect flushes
// the queue and reloads fetch_pc. Redirect takes priority over push and pop.
//
// Optional feature: define FETCH_PERF_EN to add o_bubble_count. It counts
// cycles where decode was ready but got nothing: empty cycles and redirect
// cycles. The counter saturates at all-ones.
//
// Ports:
//   i_clock          master clock, rising edge
//   i_reset          asynchronous active-high reset
//   o_address_imem   word address presented to imem (the fetch_pc register)
//   i_q_imem         imem read data for o_address_imem
//   i_redirect       flush and refetch from i_redirect_pc
//   i_redirect_pc    redirect target word address
//   i_instr_ready    decode can accept the head entry
//   o_instr_valid    head entry valid
//   o_instr_out      head instruction (0 when empty)
//   o_pc_out         head word address (0 when empty)
//   o_full           occupancy == DEPTH
//   o_empty          occupancy == 0
//   o_bubble_count   (FETCH_PERF_EN only) decode-starved cycle count
module fetch_queue #(
    parameter int unsigned DEPTH = 4  // 2, 4 or 8
) (
    input  logic        i_clock,
    input  logic        i_reset,
    output logic [11:0] o_address_imem,
    input  logic [31:0] i_q_imem,
    input  logic        i_redirect,
    input  logic [11:0] i_redirect_pc,
    input  logic        i_instr_ready,
    output logic        o_instr_valid,
    output logic [31:0] o_instr_out,
    output logic [11:0] o_pc_out,
`ifdef FETCH_PERF_EN
    output logic [31:0] o_bubble_count,
`endif
    output logic        o_full,
    output logic        o_empty
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [PtrW-1:0] PtrOne  = PtrW'(1);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);
    localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);

    logic [11:0]     r_fetch_pc;
    logic [PtrW-1:0] r_wr_ptr;
    logic [PtrW-1:0] r_rd_ptr;
    logic [CntW-1:0] r_count;
    logic [11:0]     r_mem_pc    [DEPTH];
    logic [31:0]     r_mem_instr [DEPTH];

    logic            w_full;
    logic            w_empty;
    logic            w_pop;
    logic            w_push;
    logic [11:0]     w_fetch_pc_nxt;
    logic [PtrW-1:0] w_wr_ptr_nxt;
    logic [PtrW-1:0] w_rd_ptr_nxt;
    logic [CntW-1:0] w_count_nxt;

    assign w_full  = (r_count == CntFull);
    assign w_empty = (r_count == '0);
    // A pop on a full queue frees the slot the same-cycle push writes into.
    assign w_pop   = ~w_empty & i_instr_ready & ~i_redirect;
    assign w_push  = ~i_redirect & (~w_full | w_pop);

    always_comb begin
        w_fetch_pc_nxt = r_fetch_pc;
        w_wr_ptr_nxt   = r_wr_ptr;
        w_rd_ptr_nxt   = r_rd_ptr;
        w_count_nxt    = r_count;
        if (i_redirect) begin
            w_fetch_pc_nxt = i_redirect_pc;
            w_wr_ptr_nxt   = '0;
            w_rd_ptr_nxt   = '0;
            w_count_nxt    = '0;
        end else begin
            if (w_push) begin
                w_fetch_pc_nxt = r_fetch_pc + 12'd1;  // 12-bit wrap
                w_wr_ptr_nxt   = r_wr_ptr + PtrOne;
            end
            if (w_pop) begin
                w_rd_ptr_nxt = r_rd_ptr + PtrOne;
            end
            if (w_push && !w_pop) begin
                w_count_nxt = r_count + CntOne;
            end else if (w_pop && !w_push) begin
                w_count_nxt = r_count - CntOne;
            end
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_fetch_pc <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
        end else begin
            r_fetch_pc <= w_fetch_pc_nxt;
            r_wr_ptr   <= w_wr_ptr_nxt;
            r_rd_ptr   <= w_rd_ptr_nxt;
            r_count    <= w_count_nxt;
        end
    end

    // Storage needs no reset: the head is masked to zero whenever empty.
    always_ff @(posedge i_clock) begin
        if (w_push) begin
            r_mem_pc[r_wr_ptr]    <= r_fetch_pc;
            r_mem_instr[r_wr_ptr] <= i_q_imem;
        end
    end

    assign o_address_imem = r_fetch_pc;
    assign o_instr_valid  = ~w_empty;
    assign o_instr_out    = w_empty ? 32'd0 : r_mem_instr[r_rd_ptr];
    assign o_pc_out       = w_empty ? 12'd0 : r_mem_pc[r_rd_ptr];
    assign o_full         = w_full;
    assign o_empty        = w_empty;

`ifdef FETCH_PERF_EN
    logic [31:0] r_bubble_count;
    logic        w_bubble;

    // Redirect cycles count as bubbles even if the head was valid: that
    // handshake is discarded by the flush.
    assign w_bubble = i_instr_ready & (w_empty | i_redirect);

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_bubble_count <= '0;
        end else if (w_bubble && (r_bubble_count != 32'hFFFF_FFFF)) begin
            r_bubble_count <= r_bubble_count + 32'd1;
        end
    end

    assign o_bubble_count = r_bubble_count;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue (DEPTH=4). imem model: word k = 0x1000_0000+k.
module tb_fetch_queue;

    logic        clock;
    logic        reset;
    logic [11:0] address_imem;
    logic [31:0] q_imem;
    logic        redirect;
    logic [11:0] redirect_pc;
    logic        instr_ready;
    logic        instr_valid;
    logic [31:0] instr_out;
    logic [11:0] pc_out;
    logic        full;
    logic        empty;
`ifdef FETCH_PERF_EN
    logic [31:0] bubble_count;
    logic [31:0] bubble_base;
`endif

    int n_vec  = 0;
    int n_fail = 0;

    fetch_queue #(.DEPTH(4)) dut (
        .i_clock        (clock),
        .i_reset        (reset),
        .o_address_imem (address_imem),
        .i_q_imem       (q_imem),
        .i_redirect     (redirect),
        .i_redirect_pc  (redirect_pc),
        .i_instr_ready  (instr_ready),
        .o_instr_valid  (instr_valid),
        .o_instr_out    (instr_out),
        .o_pc_out       (pc_out),
`ifdef FETCH_PERF_EN
        .o_bubble_count (bubble_count),
`endif
        .o_full         (full),
        .o_empty        (empty)
    );

    assign q_imem = 32'h1000_0000 + {20'd0, address_imem};

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Assert reset mid-cycle, then release 1 time unit after the next edge.
    task automatic do_reset();
        #2;
        reset = 1'b1;
        #1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 12'd0;
        instr_ready = 1'b0;
        #2;
        // Reset state, before any clock edge
        chk("rst_addr",  {20'd0, address_imem}, 32'd0);
        chk("rst_valid", {31'd0, instr_valid},  32'd0);
        chk("rst_instr", instr_out,             32'd0);
        chk("rst_pc",    {20'd0, pc_out},       32'd0);
        chk("rst_empty", {31'd0, empty},        32'd1);
        chk("rst_full",  {31'd0, full},         32'd0);
`ifdef FETCH_PERF_EN
        chk("rst_bubble", bubble_count, 32'd0);
`endif
        step();
        reset = 1'b0;

        // Streaming with decode always ready
        instr_ready = 1'b1;
        chk("a_addr0",  {20'd0, address_imem}, 32'd0);
        chk("a_valid0", {31'd0, instr_valid},  32'd0);
        for (int k = 0; k < 6; k++) begin
            step();
            chk("a_valid", {31'd0, instr_valid}, 32'd1);
            chk("a_pc",    {20'd0, pc_out},      k);
            chk("a_instr", instr_out,            32'h1000_0000 + k);
        end

        // Stall for 10 cycles, then drain in order
        do_reset();
        instr_ready = 1'b0;
        for (int k = 0; k < 4; k++) step();
        chk("b_full",  {31'd0, full},         32'd1);
        chk("b_empty", {31'd0, empty},        32'd0);
        chk("b_addr",  {20'd0, address_imem}, 32'd4);
        for (int k = 0; k < 6; k++) step();
        chk("b_addr_hold", {20'd0, address_imem}, 32'd4);
        chk("b_pc_hold",   {20'd0, pc_out},       32'd0);
        instr_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            chk("b_pc",    {20'd0, pc_out}, k);
            chk("b_instr", instr_out,       32'h1000_0000 + k);
            chk("b_full_keep", {31'd0, full}, 32'd1);
            step();
        end

        // Redirect with three entries queued and a pop in the same cycle
        do_reset();
        instr_ready = 1'b0;
        for (int k = 0; k < 3; k++) step();
        chk("c_pc_pre", {20'd0, pc_out}, 32'd0);
        instr_ready = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 12'h200;
        step();
        redirect = 1'b0;
        chk("c_empty", {31'd0, empty},        32'd1);
        chk("c_valid", {31'd0, instr_valid},  32'd0);
        chk("c_addr",  {20'd0, address_imem}, 32'h200);
        step();
        chk("c_pc0",    {20'd0, pc_out}, 32'h200);
        chk("c_instr0", instr_out,       32'h1000_0200);
        step();
        chk("c_pc1",    {20'd0, pc_out}, 32'h201);

        // Redirect near the top of the address space: wrap to 0
`ifdef FETCH_PERF_EN
        bubble_base = bubble_count;
`endif
        redirect    = 1'b1;
        redirect_pc = 12'hFFE;
        step();
        redirect = 1'b0;
        chk("d_valid", {31'd0, instr_valid}, 32'd0);
        step();
        chk("d_pc0", {20'd0, pc_out}, 32'hFFE);
        step();
        chk("d_pc1", {20'd0, pc_out}, 32'hFFF);
        step();
        chk("d_pc2",    {20'd0, pc_out}, 32'h000);
        chk("d_instr2", instr_out,       32'h1000_0000);
        step();
        chk("d_pc3", {20'd0, pc_out}, 32'h001);
`ifdef FETCH_PERF_EN
        chk("d_bubble_delta", bubble_count - bubble_base, 32'd2);
`endif

        // Asynchronous reset mid-cycle with the queue full
        instr_ready = 1'b0;
        for (int k = 0; k < 5; k++) step();
        chk("e_full", {31'd0, full}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("e_valid", {31'd0, instr_valid},  32'd0);
        chk("e_addr",  {20'd0, address_imem}, 32'd0);
        chk("e_full0", {31'd0, full},         32'd0);
        chk("e_pc",    {20'd0, pc_out},       32'd0);
        step();
        reset       = 1'b0;
        instr_ready = 1'b1;
        step();
        chk("e_first_pc",    {20'd0, pc_out}, 32'd0);
        chk("e_first_instr", instr_out,       32'h1000_0000);
        step();
        chk("e_second_pc", {20'd0, pc_out}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, queue entries; legal values 2, 4, 8.
REQ-002 clock  input  1  master clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-004 address_imem  output  12  word address of the instruction requested from imem this cycle.
REQ-005 q_imem  input  32  imem read data for the address_imem driven in the current cycle; valid at the next rising clock edge.
REQ-006 redirect  input  1  branch/jump taken; flush the queue and refetch.
REQ-007 redirect_pc  input  12  target word address, sampled when redirect=1.
REQ-008 instr_ready  input  1  decode stage can accept an instruction (stall = ~instr_ready).
REQ-009 instr_valid  output  1  head entry valid.
REQ-010 instr_out  output  32  head instruction.
REQ-011 pc_out  output  12  word address of the head instruction.
REQ-012 full  output  1  occupancy == DEPTH.
REQ-013 empty  output  1  occupancy == 0.

Function
REQ-014 address_imem SHALL equal the internal fetch_pc register (registered, no combinational path from inputs).
REQ-015 Push: when redirect=0 and (full=0 or a pop occurs this cycle), {fetch_pc, q_imem} SHALL be written at the tail and fetch_pc SHALL increment by 1.
REQ-016 fetch_pc arithmetic SHALL be 12-bit modulo; 4095 + 1 wraps to 0.
REQ-017 When full=1 and no pop occurs, fetch_pc SHALL hold and no entry SHALL be written.
REQ-018 Pop: instr_valid=1 and instr_ready=1 SHALL remove the head at the rising edge.
REQ-019 Simultaneous push and pop on a full queue SHALL keep occupancy at DEPTH with no loss or duplication.
REQ-020 instr_valid SHALL equal ~empty; instr_out/pc_out SHALL present the head entry, and SHALL be 0 when empty.
REQ-021 Fill latency: a pc first driven on address_imem in cycle N SHALL appear on instr_out/pc_out in cycle N+1 if the queue is empty.
REQ-022 Order: entries SHALL leave in exactly the order pushed; read/write pointers wrap modulo DEPTH.
REQ-023 Redirect SHALL have priority over push and pop: at the edge, occupancy SHALL become 0, fetch_pc SHALL load redirect_pc, and any q_imem data in that cycle SHALL be discarded.
REQ-024 In the cycle after a redirect, instr_valid SHALL be 0; the redirect target instruction SHALL appear one cycle later (REQ-021).
REQ-025 A pop handshake in the same cycle as redirect SHALL NOT be counted as consumed by decode beyond that cycle (queue is flushed regardless).
REQ-026 full and empty SHALL never both be 1.

Reset
REQ-027 On reset assertion: fetch_pc=0, address_imem=0, occupancy=0, instr_valid=0, instr_out=0, pc_out=0, empty=1, full=0, pointers=0, without waiting for a clock edge.
REQ-028 Reset mid-fill SHALL discard all queued entries; after release the first instruction delivered SHALL be pc 0.
REQ-029 The first rising edge after reset deassertion SHALL perform a normal push of pc 0.

Configuration
REQ-030 Macro FETCH_PERF_EN: when defined, the block SHALL add output bubble_count (32 bits), incrementing each cycle with instr_ready=1 and instr_valid=0 (redirect cycles included), reset to 0, saturating at 0xFFFFFFFF.
REQ-031 Without FETCH_PERF_EN, bubble_count and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-032 Reset release, imem word k = 0x1000_0000+k, instr_ready=1 -> pc_out 0,1,2,3... on consecutive cycles, instr_out matching, instr_valid=1 from cycle 1.
REQ-033 instr_ready=0 for 10 cycles (DEPTH=4) -> full=1 after 4 pushes, address_imem holds 4; release -> pcs 0..7 delivered in order, none dropped or duplicated.
REQ-034 redirect=1, redirect_pc=0x200 while queue holds 3 entries -> next cycle empty=1, instr_valid=0; following cycle pc_out=0x200, then 0x201.
REQ-035 redirect_pc=0xFFE, instr_ready=1 -> pc_out sequence 0xFFE, 0xFFF, 0x000, 0x001.
REQ-036 Reset asserted asynchronously mid-cycle with queue full -> instr_valid=0, address_imem=0 before the next edge; after release pc 0 delivered first.
REQ-037 With FETCH_PERF_EN: instr_ready=1, one redirect -> bubble_count increments by exactly 2 (redirect cycle and the empty cycle after).
